square_channel_ctrl: RTL
========================

# square_channel_ctrl

Control stage for one square channel that produces the frequency, duty and enable inputs of the square waveform generator, plus a 4-bit volume for the mixer. It contains a 512 Hz frame sequencer, a 64-step length counter, a frequency sweep unit and a volume envelope, all driven from register-write fields decoded by the sound register file.

## Interface
- CLK_DIV, 8192, I_CLK cycles per frame-sequencer tick (4.194304 MHz / 512 Hz); must be ≥ 2
- I_CLK  in  1  system clock
- I_RESET  in  1  reset, synchronous, active-high; clock I_CLK
- I_TRIGGER  in  1  one-cycle pulse, channel trigger (NR14 bit 7 write)
- I_LENGTH_LOAD  in  1  one-cycle pulse, load length from I_LENGTH (NR11 write)
- I_LENGTH  in  6  length field t1
- I_LENGTH_EN  in  1  length counter enable (NR14 bit 6)
- I_DUTY_CYCLE  in  2  duty select, passed through
- I_FREQUENCY  in  11  frequency register value
- I_SWEEP_PERIOD  in  3  sweep period; 0 = sweep timer treated as 8, no sweep updates
- I_SWEEP_NEGATE  in  1  1 = subtract
- I_SWEEP_SHIFT  in  3  sweep shift
- I_ENV_INIT  in  4  initial volume
- I_ENV_DIR  in  1  1 = increase
- I_ENV_PERIOD  in  3  envelope period; 0 = envelope frozen
- O_FREQUENCY  out  11  frequency to waveform generator
- O_DUTY_CYCLE  out  2  registered I_DUTY_CYCLE
- O_WAVEFORM_EN  out  1  channel active
- O_VOLUME  out  4  current envelope volume
- O_FRAME_STEP  out  3  current frame-sequencer step

## Operation
- All outputs registered; reset value 0 for every output and internal counter.
- Frame sequencer: divider counts 0..CLK_DIV-1; tick asserted for the cycle divider = CLK_DIV-1. On tick, action is selected by current step, then step increments mod 8. Length clocked on steps 0,2,4,6; sweep on 2,6; envelope on 7.
- DAC enable = (I_ENV_INIT != 0) | I_ENV_DIR. DAC off forces O_WAVEFORM_EN to 0 the next cycle, and a trigger with DAC off does not set it.
- Length: 7-bit counter. I_LENGTH_LOAD loads 64 − I_LENGTH. On length tick with I_LENGTH_EN and counter ≠ 0: decrement; on reaching 0, O_WAVEFORM_EN ← 0. Trigger with counter = 0 reloads 64.
- Sweep: shadow register drives O_FREQUENCY. While sweep disabled, shadow follows I_FREQUENCY every cycle.
  - Trigger: shadow ← I_FREQUENCY; timer ← period (0→8); sweep_en ← (period ≠ 0) | (shift ≠ 0).
  - If shift ≠ 0 at trigger, overflow check is performed with the same rule as a sweep tick.
  - Sweep tick: timer decrements; at 0, timer reloads.
  - On reload with sweep_en and period ≠ 0: new = shadow ± (shadow >> shift), computed 12-bit.
  - new > 2047 disables the channel and leaves shadow unchanged. Otherwise, if shift ≠ 0, shadow ← new.
  - Subtraction never underflows.
- Envelope: trigger loads volume ← I_ENV_INIT and timer ← I_ENV_PERIOD. On envelope tick with period ≠ 0: decrement timer; at 0, reload timer and step volume by ±1. Volume saturates at 15/0; once saturated, it stops changing until the next trigger.
- O_WAVEFORM_EN set by trigger (DAC on and no trigger overflow). Cleared by length expiry, sweep overflow, DAC off or reset.

## Timing
- Trigger at cycle N: O_WAVEFORM_EN, O_VOLUME and O_FREQUENCY take their new values at N+1.
- O_DUTY_CYCLE is I_DUTY_CYCLE delayed 1 cycle. Shadow tracking of I_FREQUENCY is also 1 cycle.
- Tick at cycle T: the resulting counter, volume, frequency and enable changes are visible at T+1. O_FRAME_STEP also updates at T+1.
- I_LENGTH_LOAD and I_TRIGGER in the same cycle: the load applies first, so the trigger sees a nonzero counter and does not reload 64.
- Trigger and tick in the same cycle: the trigger wins. That tick's length, sweep and envelope actions are discarded; the step still advances.
- Reset mid-operation: all state returns to 0 on the next edge, and the divider restarts at 0.

## Structure
- Package sound_pkg holds:
  - FREQ_MAX = 2047 and LENGTH_MAX = 64
  - step masks: LEN_STEPS = 8'b01010101, SWEEP_STEPS = 8'b01000100, ENV_STEPS = 8'b10000000
- Sub-module frame_sequencer (divider + 3-bit step) outputs a one-cycle tick and the step. It is instantiated once and shareable by the other channels.

## Test plan
- CLK_DIV=4, reset, then trigger with ENV_INIT=0xF: O_WAVEFORM_EN=1 and O_VOLUME=15 one cycle after the trigger. O_FRAME_STEP advances every 4 cycles.
- I_LENGTH=62 load, LENGTH_EN=1, trigger: the channel disables after the 2nd length tick (step 2 tick + 1 cycle).
- FREQUENCY=0x700, SWEEP_PERIOD=1, SHIFT=1, NEGATE=0: the trigger check passes (new = 0x380 + 0x700 = 0xA80 > 2047) → O_WAVEFORM_EN stays 0.
- FREQUENCY=0x100, PERIOD=1, SHIFT=1, NEGATE=1: O_FREQUENCY goes 0x100 → 0x080 → 0x040 on successive sweep ticks.
- ENV_INIT=2, DIR=0, PERIOD=1: volume goes 2→1→0 on the first two envelope ticks (step 7), then holds at 0 with the channel still enabled.
- ENV_INIT=0, DIR=0 while active: O_WAVEFORM_EN=0 one cycle later. A subsequent trigger leaves it at 0.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared sound-unit constants and the sweep arithmetic helper.
// Used by the square channel control stage and the frame sequencer.
package sound_pkg;

    localparam logic [11:0] FREQ_MAX   = 12'd2047;
    localparam logic [6:0]  LENGTH_MAX = 7'd64;

    localparam logic [7:0] LEN_STEPS   = 8'b01010101;
    localparam logic [7:0] SWEEP_STEPS = 8'b01000100;
    localparam logic [7:0] ENV_STEPS   = 8'b10000000;

    // 12-bit result so an overflow past FREQ_MAX is visible to the caller
    function automatic logic [11:0] sweep_calc(
        input logic [10:0] freq,
        input logic [2:0]  shift,
        input logic        negate
    );
        logic [11:0] base;
        logic [11:0] delta;
        base  = {1'b0, freq};
        delta = base >> shift;
        if (negate)
            sweep_calc = base - delta;
        else
            sweep_calc = base + delta;
    endfunction

endpackage

// File: rtl/frame_sequencer.sv
// 512 Hz frame sequencer: clock divider plus 3-bit step counter.
// One instance can be shared by every channel.
module frame_sequencer
    import sound_pkg::*;
#(
    parameter int CLK_DIV = 8192
) (
    input  logic       clk,
    input  logic       reset,
    output logic       tick,
    output logic [2:0] step
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div  <= '0;
            step <= '0;
        end else begin
            div <= tick ? '0 : div + DW'(1);
            if (tick)
                step <= step + 3'd1;
        end
    end

endmodule

// File: rtl/square_channel_ctrl.sv
// Square channel control stage: length counter, frequency sweep and
// volume envelope feeding the square waveform generator and mixer.
module square_channel_ctrl
    import sound_pkg::*;
#(
    parameter int CLK_DIV = 8192
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_TRIGGER,
    input  logic        I_LENGTH_LOAD,
    input  logic [5:0]  I_LENGTH,
    input  logic        I_LENGTH_EN,
    input  logic [1:0]  I_DUTY_CYCLE,
    input  logic [10:0] I_FREQUENCY,
    input  logic [2:0]  I_SWEEP_PERIOD,
    input  logic        I_SWEEP_NEGATE,
    input  logic [2:0]  I_SWEEP_SHIFT,
    input  logic [3:0]  I_ENV_INIT,
    input  logic        I_ENV_DIR,
    input  logic [2:0]  I_ENV_PERIOD,
    output logic [10:0] O_FREQUENCY,
    output logic [1:0]  O_DUTY_CYCLE,
    output logic        O_WAVEFORM_EN,
    output logic [3:0]  O_VOLUME,
    output logic [2:0]  O_FRAME_STEP
);

    logic        tick;
    logic [2:0]  step;
    logic [6:0]  len_cnt;
    logic [10:0] shadow;
    logic [3:0]  sweep_timer;
    logic        sweep_en;
    logic [3:0]  vol;
    logic [2:0]  env_timer;
    logic        env_active;
    logic        enable;
    logic [1:0]  duty;

    frame_sequencer #(
        .CLK_DIV (CLK_DIV)
    ) u_frame_seq (
        .clk   (I_CLK),
        .reset (I_RESET),
        .tick  (tick),
        .step  (step)
    );

    logic len_tick, sweep_tick, env_tick;
    assign len_tick   = tick & LEN_STEPS[step];
    assign sweep_tick = tick & SWEEP_STEPS[step];
    assign env_tick   = tick & ENV_STEPS[step];

    logic dac_en;
    assign dac_en = (I_ENV_INIT != 4'd0) | I_ENV_DIR;

    // Length: a same-cycle load is seen by the trigger's zero test
    logic [6:0] load_val, len_base;
    logic       len_dec, len_expire;
    assign load_val   = LENGTH_MAX - {1'b0, I_LENGTH};
    assign len_base   = I_LENGTH_LOAD ? load_val : len_cnt;
    assign len_dec    = len_tick & I_LENGTH_EN & (len_cnt != 7'd0);
    assign len_expire = len_dec & (len_cnt == 7'd1)
                      & ~I_LENGTH_LOAD & ~I_TRIGGER;

    always_ff @(posedge I_CLK) begin
        if (I_RESET)
            len_cnt <= '0;
        else if (I_LENGTH_LOAD || I_TRIGGER) begin
            if (I_TRIGGER && len_base == 7'd0)
                len_cnt <= LENGTH_MAX;
            else
                len_cnt <= len_base;
        end else if (len_dec)
            len_cnt <= len_cnt - 7'd1;
    end

    logic [3:0]  period_eff;
    logic [11:0] trig_calc, sw_calc;
    logic        trig_ovf, sw_reload, sw_fire, sweep_ovf;
    assign period_eff = (I_SWEEP_PERIOD == 3'd0) ? 4'd8
                                                 : {1'b0, I_SWEEP_PERIOD};
    assign trig_calc  = sweep_calc(I_FREQUENCY, I_SWEEP_SHIFT, I_SWEEP_NEGATE);
    assign sw_calc    = sweep_calc(shadow, I_SWEEP_SHIFT, I_SWEEP_NEGATE);
    assign trig_ovf   = (I_SWEEP_SHIFT != 3'd0) & (trig_calc > FREQ_MAX);
    assign sw_reload  = sweep_tick & (sweep_timer <= 4'd1);
    assign sw_fire    = sw_reload & sweep_en & (I_SWEEP_PERIOD != 3'd0);
    assign sweep_ovf  = sw_fire & (sw_calc > FREQ_MAX) & ~I_TRIGGER;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            shadow      <= '0;
            sweep_timer <= '0;
            sweep_en    <= 1'b0;
        end else if (I_TRIGGER) begin
            shadow      <= I_FREQUENCY;
            sweep_timer <= period_eff;
            sweep_en    <= (I_SWEEP_PERIOD != 3'd0) | (I_SWEEP_SHIFT != 3'd0);
        end else begin
            if (!sweep_en)
                shadow <= I_FREQUENCY;
            if (sw_reload) begin
                sweep_timer <= period_eff;
                if (sw_fire && !(sw_calc > FREQ_MAX) && I_SWEEP_SHIFT != 3'd0)
                    shadow <= sw_calc[10:0];
            end else if (sweep_tick)
                sweep_timer <= sweep_timer - 4'd1;
        end
    end

    // Envelope stops for good once it reaches either rail
    logic [3:0] vol_next;
    logic       at_limit;
    assign vol_next = I_ENV_DIR ? vol + 4'd1 : vol - 4'd1;
    assign at_limit = I_ENV_DIR ? (vol == 4'd15) : (vol == 4'd0);

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            vol        <= '0;
            env_timer  <= '0;
            env_active <= 1'b0;
        end else if (I_TRIGGER) begin
            vol        <= I_ENV_INIT;
            env_timer  <= I_ENV_PERIOD;
            env_active <= 1'b1;
        end else if (env_tick && I_ENV_PERIOD != 3'd0) begin
            if (env_timer <= 3'd1) begin
                env_timer <= I_ENV_PERIOD;
                if (env_active) begin
                    if (at_limit)
                        env_active <= 1'b0;
                    else begin
                        vol <= vol_next;
                        if (vol_next == 4'd15 || vol_next == 4'd0)
                            env_active <= 1'b0;
                    end
                end
            end else
                env_timer <= env_timer - 3'd1;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            enable <= 1'b0;
            duty   <= '0;
        end else begin
            duty <= I_DUTY_CYCLE;
            if (!dac_en)
                enable <= 1'b0;
            else if (I_TRIGGER)
                enable <= ~trig_ovf;
            else if (len_expire || sweep_ovf)
                enable <= 1'b0;
        end
    end

    assign O_FREQUENCY   = shadow;
    assign O_DUTY_CYCLE  = duty;
    assign O_WAVEFORM_EN = enable;
    assign O_VOLUME      = vol;
    assign O_FRAME_STEP  = step;

endmodule
